// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and constants for the instruction-memory loader
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_FLUSH,
      S_RUN,
      S_ERR
   } state_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

   // A program larger than the memory is rejected; exactly full is allowed.
   function automatic logic too_many_words(input logic [15:0] n, input int addr_w);
      return {16'd0, n} > (32'd1 << addr_w);
   endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - assembles little-endian 32-bit words from a byte stream
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  data,
   output logic        word_end,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [23:0] shift;
   logic [1:0]  cnt;

   assign word_end = (cnt == 2'(WORD_BYTES - 1));

   // The assembled word lives in its own register so it stays put while the next word shifts in.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift      <= '0;
         cnt        <= '0;
         word_valid <= 1'b0;
         word       <= '0;
      end else begin
         word_valid <= 1'b0;
         if (en) begin
            if (word_end) begin
               word       <= {data, shift};
               word_valid <= 1'b1;
               cnt        <= '0;
            end else begin
               shift <= {data, shift[23:8]};
               cnt   <= cnt + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: byte stream to instruction memory, holds the core in reset until loaded
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = ADDR_W + 1;

   state_t            state;
   logic [7:0]        n_lo;
   logic [CNT_W-1:0]  n_words;
   logic [CNT_W-1:0]  word_cnt;
   logic [15:0]       n_hdr;
   logic              accept;
   logic              pack_en;
   logic              word_end;

   assign accept  = in_valid && in_ready;
   assign pack_en = accept && (state == S_DATA);
   assign n_hdr   = {in_data, n_lo};

   byte_packer u_packer (
      .clk        (clk),
      .rst        (rst),
      .en         (pack_en),
      .data       (in_data),
      .word_end   (word_end),
      .word_valid (wr_en),
      .word       (wr_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_HDR0;
         in_ready <= 1'b1;
         cpu_rst  <= 1'b1;
         done     <= 1'b0;
         err      <= 1'b0;
         n_lo     <= '0;
         n_words  <= '0;
         word_cnt <= '0;
         wr_addr  <= '0;
      end else begin
         if (wr_en)
            wr_addr <= wr_addr + 1'b1;
         case (state)
            S_HDR0: begin
               if (accept) begin
                  n_lo  <= in_data;
                  state <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (accept) begin
                  if (n_hdr == '0) begin
                     state    <= S_RUN;
                     in_ready <= 1'b0;
                     cpu_rst  <= 1'b0;
                     done     <= 1'b1;
                  end else if (too_many_words(n_hdr, ADDR_W)) begin
                     state    <= S_ERR;
                     in_ready <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     n_words <= CNT_W'(n_hdr);
                     state   <= S_DATA;
                  end
               end
            end
            S_DATA: begin
               if (pack_en && word_end) begin
                  word_cnt <= word_cnt + 1'b1;
                  // Last byte of the program: stop accepting while the final write drains.
                  if (word_cnt == n_words - 1'b1) begin
                     state    <= S_FLUSH;
                     in_ready <= 1'b0;
                  end
               end
            end
            S_FLUSH: begin
               state   <= S_RUN;
               cpu_rst <= 1'b0;
               done    <= 1'b1;
            end
            S_RUN, S_ERR: begin
            end
            default: state <= S_HDR0;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

   localparam int ADDR_W = 7;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic              cpu_rst;
   logic              done;
   logic              err;

   int checks   = 0;
   int errors   = 0;
   int n_writes = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct {
      int          n;
      logic [31:0] seed;
      bit          gap;
      bit          exp_err;
   } vec_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   vec_t vecs[7];

   always #5 clk = ~clk;

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .cpu_rst  (cpu_rst),
      .done     (done),
      .err      (err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [31:0] seed, input int i);
      return (seed == 32'd0) ? 32'(i) : seed ^ (32'(i) * 32'h01010101);
   endfunction

   // Scoreboard: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (wr_en) begin
         n_writes++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data 0x%08h with none expected", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
            check("wr_data", wr_data, mon_e.data);
         end
      end
   end

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b, input bit gap);
      bit acc;
      bit fin;
      int t;
      t        = 0;
      fin      = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      while (!fin) begin
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            fin = 1'b1;
         end else begin
            t++;
            if (t > 50) begin
               checks++;
               errors++;
               $display("FAIL accept_timeout: byte 0x%02h not accepted, in_ready %0b expected 1", b, in_ready);
               fin = 1'b1;
            end
         end
      end
      if (gap) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_program(input int n, input logic [31:0] seed, input bit gap, input bit exp_err);
      logic [31:0] w;
      push_byte(n[7:0], gap);
      push_byte(n[15:8], gap);
      if (!exp_err) begin
         for (int i = 0; i < n; i++) begin
            w = word_of(seed, i);
            exp_q.push_back('{addr: ADDR_W'(i), data: w});
            for (int k = 0; k < 4; k++)
               push_byte(w[8*k +: 8], gap);
         end
      end
      in_valid = 1'b0;
   endtask

   initial begin
      int w0;
      vecs[0] = '{1,   32'h00100313, 1'b0, 1'b0};
      vecs[1] = '{3,   32'hDEADBEEF, 1'b1, 1'b0};
      vecs[2] = '{0,   32'h00000000, 1'b0, 1'b0};
      vecs[3] = '{129, 32'h00000000, 1'b0, 1'b1};
      vecs[4] = '{128, 32'h00000000, 1'b0, 1'b0};
      vecs[5] = '{2,   32'hA5A50F0F, 1'b1, 1'b0};
      vecs[6] = '{256, 32'h00000000, 1'b1, 1'b1};

      do_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_wr_en",    32'(wr_en),    32'd0);
      check("rst_wr_addr",  32'(wr_addr),  32'd0);
      check("rst_wr_data",  wr_data,       32'd0);
      check("rst_cpu_rst",  32'(cpu_rst),  32'd1);
      check("rst_done",     32'(done),     32'd0);
      check("rst_err",      32'(err),      32'd0);

      for (int v = 0; v < 7; v++) begin
         do_reset();
         w0 = n_writes;
         send_program(vecs[v].n, vecs[v].seed, vecs[v].gap, vecs[v].exp_err);
         repeat (3) @(posedge clk);
         #1;
         check($sformatf("v%0d_writes", v),   32'(n_writes - w0), vecs[v].exp_err ? 32'd0 : 32'(vecs[v].n));
         check($sformatf("v%0d_err", v),      32'(err),     32'(vecs[v].exp_err));
         check($sformatf("v%0d_cpu_rst", v),  32'(cpu_rst), 32'(vecs[v].exp_err));
         check($sformatf("v%0d_done", v),     32'(done),    32'(!vecs[v].exp_err));
         check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'd0);
         check($sformatf("v%0d_wr_addr", v),  32'(wr_addr),
               vecs[v].exp_err ? 32'd0 : 32'(vecs[v].n % (1 << ADDR_W)));
         check($sformatf("v%0d_q_empty", v),  32'(exp_q.size()), 32'd0);
      end

      // Single word with continuous valid: exact write and release timing.
      do_reset();
      push_byte(8'h01, 1'b0);
      push_byte(8'h00, 1'b0);
      push_byte(8'h13, 1'b0);
      push_byte(8'h03, 1'b0);
      push_byte(8'h10, 1'b0);
      exp_q.push_back('{addr: '0, data: 32'h00100313});
      push_byte(8'h00, 1'b0);
      check("t1_flush_wr_en",    32'(wr_en),    32'd1);
      check("t1_flush_cpu_rst",  32'(cpu_rst),  32'd1);
      check("t1_flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      check("t1_run_cpu_rst", 32'(cpu_rst), 32'd0);
      check("t1_run_done",    32'(done),    32'd1);
      check("t1_run_wr_en",   32'(wr_en),   32'd0);
      in_data = 8'hAA;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check("t1_run_ignores_in", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t1_rerst_cpu_rst",  32'(cpu_rst),  32'd1);
      check("t1_rerst_done",     32'(done),     32'd0);
      check("t1_rerst_in_ready", 32'(in_ready), 32'd1);

      // Empty program releases one cycle after the second header byte.
      do_reset();
      push_byte(8'h00, 1'b0);
      push_byte(8'h00, 1'b0);
      in_valid = 1'b0;
      check("t2_cpu_rst",  32'(cpu_rst),  32'd0);
      check("t2_done",     32'(done),     32'd1);
      check("t2_in_ready", 32'(in_ready), 32'd0);

      // Rejected header is sticky until reset.
      do_reset();
      push_byte(8'h81, 1'b0);
      push_byte(8'h00, 1'b0);
      in_valid = 1'b0;
      check("t3_err",      32'(err),      32'd1);
      check("t3_in_ready", 32'(in_ready), 32'd0);
      check("t3_cpu_rst",  32'(cpu_rst),  32'd1);
      do_reset();
      check("t3_rst_err",      32'(err),      32'd0);
      check("t3_rst_in_ready", 32'(in_ready), 32'd1);

      // Reset after six payload bytes, then a fresh one-word stream.
      do_reset();
      push_byte(8'h02, 1'b0);
      push_byte(8'h00, 1'b0);
      exp_q.push_back('{addr: '0, data: 32'h44332211});
      push_byte(8'h11, 1'b0);
      push_byte(8'h22, 1'b0);
      push_byte(8'h33, 1'b0);
      push_byte(8'h44, 1'b0);
      push_byte(8'h55, 1'b0);
      push_byte(8'h66, 1'b0);
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t4_wr_addr",  32'(wr_addr),  32'd0);
      check("t4_cpu_rst",  32'(cpu_rst),  32'd1);
      check("t4_in_ready", 32'(in_ready), 32'd1);
      check("t4_done",     32'(done),     32'd0);
      send_program(1, 32'hCAFEF00D, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check("t4_new_done",    32'(done),          32'd1);
      check("t4_new_q_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction-memory loader for the single-cycle RV32 core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory starting at word 0. It holds the core in reset until the whole program is written, then releases it. It is the writer side of the instruction memory that the core's fetch path reads, and it replaces the bench-side forcing of PC and memory contents.

## Interface
- `ADDR_W`, default 7: word-address width of instruction memory (128 words).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  the source presents a byte.
- `in_data`  in  8  byte value.
- `in_ready`  out  1  the loader can accept a byte; a transfer occurs on an edge where `in_valid && in_ready`.
- `wr_en`  out  1  one-cycle instruction-memory write strobe.
- `wr_addr`  out  ADDR_W  word address of the write.
- `wr_data`  out  32  word to write.
- `cpu_rst`  out  1  reset to the core; high until the load completes.
- `done`  out  1  the load is complete and the core is running.
- `err`  out  1  the header was rejected; sticky until `rst`.

## Operation
- Stream format: 2-byte header N (word count, little-endian, low byte first), followed by 4·N payload bytes. Each word is sent low byte first, so byte0 goes to `wr_data[7:0]`.
- States:
  - HDR0: accept the low byte of N.
  - HDR1: accept the high byte of N.
  - DATA: accept payload bytes.
  - FLUSH: issue the final write.
  - RUN: program loaded, core released.
  - ERR: header rejected.
- HDR1 exit, decided on the accepted byte:
  - N == 0: go to RUN.
  - N > 2^ADDR_W: go to ERR.
  - Otherwise: go to DATA.
- DATA:
  - A 2-bit byte counter tracks position within the word.
  - On acceptance of the 4th byte of a word, the next edge drives `wr_en=1` for one cycle with the assembled word and the current `wr_addr`.
  - `wr_addr` increments after each write.
  - A word counter compares against N. When the 4th byte of word N−1 is accepted, the state goes to FLUSH.
- FLUSH: lasts one cycle (the final `wr_en` cycle), then goes to RUN.
- `in_ready` is 1 in HDR0, HDR1 and DATA, and 0 in FLUSH, RUN and ERR.
- RUN: `cpu_rst=0`, `done=1`. Further input is ignored (not accepted). RUN is left only via `rst`.
- ERR: `err=1`, `cpu_rst=1`, no writes. ERR is left only via `rst`.
- `in_valid` low mid-word: the partial word is held indefinitely, with no timeout.

## Timing
- Reset values (the edge with `rst=1`): state HDR0, `in_ready=1`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `cpu_rst=1`, `done=0`, `err=0`. Byte and word counters are 0.
- Throughput: one byte per cycle while `in_valid` is held high.
- Write latency: `wr_en` is asserted exactly 1 cycle after the edge that accepts the 4th byte.
- `wr_addr`/`wr_data` are stable during `wr_en`. The memory samples them on the next edge.
- Release latency:
  - `cpu_rst` falls 2 cycles after the edge accepting the final byte: FLUSH, then RUN.
  - This guarantees the last write is committed before the first fetch.
  - For N=0, `cpu_rst` falls 1 cycle after the HDR1 acceptance.
- `cpu_rst`, `done` and `err` are registered outputs, glitch-free.
- Reset mid-load: everything returns to HDR0 values and `cpu_rst` stays high. Words already written remain in memory (no clear). A fresh header is required.
- Reset during RUN: `cpu_rst` reasserts on the same edge, and the loader waits for a new stream.
- N == 2^ADDR_W is legal. The last write uses `wr_addr` = all-ones, after which `wr_addr` wraps to 0 unused.

## Structure
- Package `imem_loader_pkg`:
  - state enum (HDR0, HDR1, DATA, FLUSH, RUN, ERR)
  - `HDR_BYTES=2`
  - `WORD_BYTES=4`
- Sub-module `byte_packer`: a shift-in register plus a 2-bit counter that emits `word_valid` with a 32-bit word. The top-level FSM owns the header, addressing and `cpu_rst`.

## Test plan
- Single word: bytes 01 00 13 03 10 00 with continuous valid → one `wr_en` at `wr_addr=0` with `wr_data=0x00100313`; `cpu_rst` falls 2 cycles after byte `00`; `done=1`.
- Three words with `in_valid` toggled every other cycle → writes at addresses 0, 1, 2 with correct words; no byte lost or duplicated; `in_ready` drops after the last byte.
- Header N=0 (00 00) → no `wr_en`; `cpu_rst=0` and `done=1` one cycle after the second header byte.
- Header N=129 (81 00) with ADDR_W=7 → `err=1`, `in_ready=0`, `cpu_rst` stays 1, no writes; `rst` returns to HDR0.
- `rst` asserted after 6 payload bytes → `wr_addr=0`, `cpu_rst=1`, `in_ready=1`; a new stream with N=1 writes at address 0.
- Full memory (N=128, pattern word i = i) → 128 writes at addresses 0..127, last `wr_data=0x0000007F`; then RUN; bytes presented afterward are not accepted.
